iiitb_pattern_det: RTL
======================

# iiitb_pattern_det

Parametrised serial pattern detector; successor to the fixed 4-bit "1010" sequence detector. Detects a run-time programmable bit pattern of 1 to PAT_W bits on a qualified serial input. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. Sits between the serial front end and the event/status logic; reset configuration reproduces the legacy 1010 overlapping detector.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- RST_PAT, 8'b0000_1010: pattern loaded at reset, PAT_W bits wide.
- RST_LEN, 4: pattern length loaded at reset.
- RST_OVL, 1: overlap mode loaded at reset.
- LEN_W, derived = $clog2(PAT_W+1); not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- din_valid  in  1  din sampled only when 1.
- din  in  1  serial data bit.
- load  in  1  one-cycle strobe; latches pat/pat_len/ovl.
- pat  in  PAT_W  pattern; pat[len-1] is the first bit received, pat[0] the last.
- pat_len  in  LEN_W  pattern length.
- ovl  in  1  1 = overlapping, 0 = non-overlapping.
- clr_cnt  in  1  clears match_cnt.
- y  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- armed  out  1  configured length is valid (≠0).

## Operation
- State: hist[PAT_W-1:0], fill[LEN_W-1:0], pat_q, len_q, ovl_q, match_cnt, y.
- Reset (reset=0 at an edge):
  - hist=0, fill=0, y=0, match_cnt=0.
  - pat_q=RST_PAT, len_q=RST_LEN, ovl_q=RST_OVL, armed=1.
- Load (priority over data):
  - pat_q←pat, ovl_q←ovl.
  - len_q←min(pat_len, PAT_W); pat_len>PAT_W is clamped to PAT_W.
  - hist←0, fill←0, y←0. din is ignored that cycle; match_cnt is unchanged.
  - pat_len=0 gives armed=0: never matches until the next valid load.
- Data (din_valid=1, no load):
  - hist←{hist[PAT_W-2:0], din}.
  - fill←min(fill+1, PAT_W).
  - Match when armed, fill+1 ≥ len_q, and the new hist[len_q-1:0] == pat_q[len_q-1:0]. Bits of pat_q above len_q are don't-care.
  - On match: y←1.
    - ovl_q=1: fill keeps its increment, so the tail of this match may start the next one.
    - ovl_q=0: fill←0, so the next match needs len_q fresh bits.
- din_valid=0 and no load: hist and fill hold, y←0. Gaps never break a partial pattern.
- Counter:
  - Match: match_cnt+1, saturating at 2^CNT_W-1.
  - clr_cnt alone: match_cnt←0.
  - clr_cnt with a match in the same cycle: match_cnt←1.
- No separate FSM: fill acts as the fill state, with states EMPTY(0), PARTIAL(<len_q) and PRIMED(≥len_q). Transitions follow the rules above.

## Timing
- Latency: the completing bit is sampled at edge k; y=1 and match_cnt is updated from edge k until edge k+1.
- y is registered and glitch-free, high for exactly one cycle per match.
- Back-to-back overlapping matches with len_q=1 or a periodic pattern give y high on consecutive cycles.
- Load takes effect at its edge; the first sample under the new config is at the next valid edge.
- Reset mid-pattern discards the partial history; no match can use bits sampled before reset.
- Outputs depend only on registers; no combinational input-to-output paths.

## Test plan
- Reset defaults, overlapping, din_valid=1, stream 1,0,1,0,1,0 → y pulses after bits 4 and 6; match_cnt=2; armed=1.
- Load ovl=0 with pattern 1010 and len 4, same stream → y pulses after bit 4 only; match_cnt=1.
- Load pat=8'b0000_0110, len 3, ovl=1:
  - stream 1,1,0,1,1,0 → y after bits 3 and 6.
  - repeat with din_valid=0 gaps of 2 cycles between bits → identical match positions.
- CNT_W=2, defaults, stream 1,0 repeated ×6 (5 overlapping matches) → match_cnt saturates at 3. Then clr_cnt in a match cycle → match_cnt=1.
- Reset mid-pattern: 1,0,1, reset low one edge, then 0 → no y. Then 1,0,1,0 → y after the final 0.
- Config edge cases:
  - pat_len=0 → armed=0; no y for any stream.
  - pat_len=15 with PAT_W=8 → len_q=8; pattern 8'hA5 matches after exactly 8 bits.
  - load asserted together with din_valid → that bit is dropped and hist clears.

Source files
------------

// File: rtl/iiitb_pattern_det.sv
// rtl/iiitb_pattern_det.sv - programmable serial pattern detector with saturating match counter
// fill_q tracks how many valid bits of hist_q belong to the current attempt (EMPTY/PARTIAL/PRIMED).
module iiitb_pattern_det #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_1010,
  parameter int               RST_LEN = 4,
  parameter bit               RST_OVL = 1'b1,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             ovl,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic [PAT_W-1:0] hist_new;
  logic [PAT_W-1:0] mask;
  logic [LEN_W:0]   fill_p1;
  logic [CNT_W-1:0] cnt_base;
  logic             primed;
  logic             match;

  assign armed     = (len_q != '0);
  assign y         = y_q;
  assign match_cnt = match_cnt_q;

  always_comb begin
    hist_new = {hist_q[PAT_W-2:0], din};
    fill_p1  = {1'b0, fill_q} + 1'b1;
    primed   = (fill_p1 >= {1'b0, len_q});
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    // Bits of the pattern above len_q are masked out so they never affect a match.
    match = !load && din_valid && armed && primed &&
            ((hist_new & mask) == (pat_q & mask));
  end

  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    y_d         = 1'b0;
    match_cnt_d = match_cnt_q;

    if (load) begin
      pat_d  = pat;
      ovl_d  = ovl;
      len_d  = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = hist_new;
      fill_d = (fill_p1 > (LEN_W + 1)'(PAT_W)) ? LEN_W'(PAT_W) : fill_p1[LEN_W-1:0];
      if (match) begin
        y_d = 1'b1;
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end

    // A clear coinciding with a match leaves the count at one.
    cnt_base = clr_cnt ? '0 : match_cnt_q;
    if (match && (cnt_base != '1)) begin
      match_cnt_d = cnt_base + 1'b1;
    end else begin
      match_cnt_d = cnt_base;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q      <= '0;
      fill_q      <= '0;
      pat_q       <= RST_PAT;
      len_q       <= LEN_W'(RST_LEN);
      ovl_q       <= RST_OVL;
      y_q         <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      y_q         <= y_d;
      match_cnt_q <= match_cnt_d;
    end
  end

endmodule
